// File: rtl/inst_fetch_if.sv
// Instruction ROM bus between the fetch stage (master) and a zero-latency ROM (slave).
// The ROM answers rom_addr in the same cycle with a data word and an accessible flag.
interface inst_fetch_if;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        rom_accessable;

   modport master (
      output rom_addr,
      input  rom_data,
      input  rom_accessable
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output rom_accessable
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches from the instruction ROM and fills the IF/ID register.
// Inaccessible fetches redirect to EXC_VECTOR; a second consecutive fault halts until reset.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_RUN   | normal sequential / redirected fetching
// S_REDIR | first fetch at EXC_VECTOR after a fault; another fault halts
// S_HALT  | double fault, PC frozen, IF/ID held as bubble until reset
module inst_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  logic                exc_req,
   input  logic                jr_req,
   input  logic [31:0]         jr_target,
   input  logic                br_req,
   input  logic [31:0]         br_target,
   inst_fetch_if.master        rom,
   output logic [31:0]         if_inst,
   output logic [31:0]         if_pc,
   output logic [31:0]         if_pc_plus4,
   output logic                if_valid,
   output logic                fault,
   output logic [31:0]         fault_addr,
   output logic [7:0]          fault_count,
   output logic                halted
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_REDIR = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] inst_nxt, ifpc_nxt, faddr_nxt;
   logic        valid_nxt, fault_nxt, halted_nxt;
   logic [7:0]  count_nxt;
   logic [7:0]  count_inc;

   assign rom.rom_addr = pc;
   assign if_pc_plus4  = if_pc + 32'd4;
   assign count_inc    = (fault_count == 8'hFF) ? 8'hFF : fault_count + 8'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_RUN;
         pc          <= RESET_VECTOR;
         if_inst     <= 32'd0;
         if_pc       <= 32'd0;
         if_valid    <= 1'b0;
         fault       <= 1'b0;
         fault_addr  <= 32'd0;
         fault_count <= 8'd0;
         halted      <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         if_inst     <= inst_nxt;
         if_pc       <= ifpc_nxt;
         if_valid    <= valid_nxt;
         fault       <= fault_nxt;
         fault_addr  <= faddr_nxt;
         fault_count <= count_nxt;
         halted      <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      inst_nxt   = if_inst;
      ifpc_nxt   = if_pc;
      valid_nxt  = if_valid;
      fault_nxt  = 1'b0;
      faddr_nxt  = fault_addr;
      count_nxt  = fault_count;
      halted_nxt = halted;

      case (state)
         S_HALT: begin
            inst_nxt  = 32'd0;
            valid_nxt = 1'b0;
         end
         default: begin
            if (stall) begin
               // flush still squashes the held instruction while the PC waits
               if (flush) begin
                  inst_nxt  = 32'd0;
                  valid_nxt = 1'b0;
               end
            end else if (!rom.rom_accessable) begin
               // a fault outranks every redirect request in the same cycle
               fault_nxt = 1'b1;
               faddr_nxt = pc;
               count_nxt = count_inc;
               inst_nxt  = 32'd0;
               valid_nxt = 1'b0;
               ifpc_nxt  = pc;
               pc_nxt    = EXC_VECTOR;
               if (state == S_REDIR) begin
                  halted_nxt = 1'b1;
                  state_nxt  = S_HALT;
               end else begin
                  state_nxt  = S_REDIR;
               end
            end else begin
               state_nxt = S_RUN;
               ifpc_nxt  = pc;
               valid_nxt = !flush;
               inst_nxt  = flush ? 32'd0 : rom.rom_data;
               if (exc_req)
                  pc_nxt = EXC_VECTOR;
               else if (jr_req)
                  pc_nxt = jr_target;
               else if (br_req)
                  pc_nxt = br_target;
               else
                  pc_nxt = pc + 32'd4;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a rule-level model of the fetch stage.
module tb_inst_fetch;
   localparam logic [31:0] RESET_VEC = 32'h8000_0000;
   localparam logic [31:0] EXC_VEC   = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, exc_req = 1'b0, jr_req = 1'b0, br_req = 1'b0;
   logic [31:0] jr_target = 32'd0, br_target = 32'd0;
   logic        deny = 1'b0;
   logic [31:0] if_inst, if_pc, if_pc_plus4, fault_addr;
   logic        if_valid, fault, halted;
   logic [7:0]  fault_count;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [31:0] m_pc, m_inst, m_ifpc, m_faddr;
   logic        m_valid, m_fault, m_halted, m_after;
   logic [7:0]  m_fcount;

   inst_fetch_if rom_bus ();

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h8000_0000: rom_word = 32'h3c11_0040;
         32'h8000_0004: rom_word = 32'h0810_0055;
         32'h8000_0008: rom_word = 32'h0220_0008;
         default:       rom_word = {a[15:0], ~a[31:16]};
      endcase
   endfunction

   assign rom_bus.rom_data       = rom_word(rom_bus.rom_addr);
   assign rom_bus.rom_accessable = !deny && (rom_bus.rom_addr[1:0] == 2'b00);

   inst_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .exc_req     (exc_req),
      .jr_req      (jr_req),
      .jr_target   (jr_target),
      .br_req      (br_req),
      .br_target   (br_target),
      .rom         (rom_bus.master),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4),
      .if_valid    (if_valid),
      .fault       (fault),
      .fault_addr  (fault_addr),
      .fault_count (fault_count),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_pc = RESET_VEC; m_inst = 0; m_ifpc = 0; m_faddr = 0;
      m_valid = 0; m_fault = 0; m_halted = 0; m_after = 0; m_fcount = 0;
   endtask

   // drive one cycle of inputs, advance the model across the clock edge, settle 1ns after it
   task automatic drive(input bit st, input bit fl, input bit ex, input bit jr, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt, input bit dn);
      logic        acc;
      logic [31:0] word;
      stall = st; flush = fl; exc_req = ex; jr_req = jr; jr_target = jt;
      br_req = br; br_target = bt; deny = dn;
      acc  = !dn && (m_pc[1:0] == 2'b00);
      word = rom_word(m_pc);
      @(posedge clk);
      m_fault = 0;
      if (m_halted) begin
         m_valid = 0; m_inst = 0;
      end else if (st) begin
         if (fl) begin m_valid = 0; m_inst = 0; end
      end else if (!acc) begin
         m_fault = 1; m_faddr = m_pc;
         if (m_fcount != 8'hFF) m_fcount = m_fcount + 8'd1;
         m_ifpc = m_pc; m_inst = 0; m_valid = 0;
         if (m_after) m_halted = 1;
         m_after = 1;
         m_pc = EXC_VEC;
      end else begin
         m_after = 0; m_ifpc = m_pc; m_valid = !fl; m_inst = fl ? 32'd0 : word;
         if (ex)      m_pc = EXC_VEC;
         else if (jr) m_pc = jt;
         else if (br) m_pc = bt;
         else         m_pc = m_pc + 32'd4;
      end
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 32'd0, 0, 32'd0, 0);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      stall = 0; flush = 0; exc_req = 0; jr_req = 0; br_req = 0; deny = 0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      #12;
      total++; if (rom_bus.rom_addr !== RESET_VEC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", rom_bus.rom_addr, RESET_VEC); end
      total++; if (if_inst !== 32'd0) begin bad++; $display("FAIL reset_inst got=%h exp=0", if_inst); end
      total++; if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd4) begin bad++; $display("FAIL reset_ifpc got=%h/%h exp=0/4", if_pc, if_pc_plus4); end
      total++; if ({if_valid, fault, halted} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {if_valid, fault, halted}); end
      total++; if (fault_addr !== 32'd0 || fault_count !== 8'd0) begin bad++; $display("FAIL reset_fault got=%h/%h exp=0/0", fault_addr, fault_count); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_inst [3];
      exp_inst[0] = 32'h3c11_0040; exp_inst[1] = 32'h0810_0055; exp_inst[2] = 32'h0220_0008;
      for (int i = 0; i < 3; i++) begin
         idle();
         total++; if (if_inst !== exp_inst[i] || if_valid !== 1'b1) begin bad++; $display("FAIL seq_inst%0d got=%h/%b exp=%h/1", i, if_inst, if_valid, exp_inst[i]); end
         total++; if (if_pc !== RESET_VEC + 32'(4*i) || if_pc_plus4 !== RESET_VEC + 32'(4*i+4)) begin bad++; $display("FAIL seq_pc%0d got=%h/%h", i, if_pc, if_pc_plus4); end
         total++; if (rom_bus.rom_addr !== RESET_VEC + 32'(4*i+4)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, rom_bus.rom_addr, RESET_VEC + 32'(4*i+4)); end
      end
   endtask

   task automatic test_redirect();
      drive(0, 0, 0, 1, 32'h0040_0020, 1, 32'h0040_0010, 0);
      total++; if (rom_bus.rom_addr !== 32'h0040_0020) begin bad++; $display("FAIL jr_over_br got=%h exp=00400020", rom_bus.rom_addr); end
      drive(0, 0, 1, 1, 32'h0040_0030, 0, 32'd0, 0);
      total++; if (rom_bus.rom_addr !== EXC_VEC) begin bad++; $display("FAIL exc_over_jr got=%h exp=%h", rom_bus.rom_addr, EXC_VEC); end
      drive(0, 0, 0, 0, 32'd0, 1, 32'h0040_0004, 0);
      total++; if (rom_bus.rom_addr !== 32'h0040_0004 || if_inst !== 32'h0220_0008) begin bad++; $display("FAIL br_taken got=%h/%h", rom_bus.rom_addr, if_inst); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, i == 1, 0, 32'd0, i == 2, 32'h0000_1000, 0);
         total++; if (rom_bus.rom_addr !== 32'h0040_0004 || if_inst !== 32'h0220_0008 || if_pc !== EXC_VEC)
            begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%h", i, rom_bus.rom_addr, if_inst, if_pc); end
      end
      drive(1, 1, 0, 0, 32'd0, 0, 32'd0, 0);
      total++; if (if_valid !== 1'b0 || if_inst !== 32'd0 || rom_bus.rom_addr !== 32'h0040_0004)
         begin bad++; $display("FAIL stall_flush got=%b/%h/%h", if_valid, if_inst, rom_bus.rom_addr); end
      idle();
      total++; if (rom_bus.rom_addr !== 32'h0040_0008 || if_pc !== 32'h0040_0004 || if_inst !== 32'h0004_FFBF || if_valid !== 1'b1)
         begin bad++; $display("FAIL stall_resume got=%h/%h/%h/%b", rom_bus.rom_addr, if_pc, if_inst, if_valid); end
   endtask

   task automatic test_fault();
      drive(0, 0, 0, 0, 32'd0, 1, 32'h0040_0100, 0);
      drive(0, 0, 0, 1, 32'h0040_0200, 0, 32'd0, 1);
      total++; if (fault !== 1'b1 || fault_addr !== 32'h0040_0100 || fault_count !== 8'd1)
         begin bad++; $display("FAIL fault_pulse got=%b/%h/%h", fault, fault_addr, fault_count); end
      total++; if (if_valid !== 1'b0 || rom_bus.rom_addr !== EXC_VEC) begin bad++; $display("FAIL fault_redir got=%b/%h", if_valid, rom_bus.rom_addr); end
      idle();
      total++; if (fault !== 1'b0 || if_valid !== 1'b1 || if_inst !== 32'h0220_0008 || halted !== 1'b0)
         begin bad++; $display("FAIL fault_recover got=%b/%b/%h/%b", fault, if_valid, if_inst, halted); end
   endtask

   task automatic test_double_fault();
      apply_reset();
      drive(0, 0, 0, 0, 32'd0, 1, 32'h0040_0100, 0);
      drive(0, 0, 0, 0, 32'd0, 0, 32'd0, 1);
      drive(0, 0, 0, 0, 32'd0, 0, 32'd0, 1);
      total++; if (fault !== 1'b1 || fault_count !== 8'd2 || halted !== 1'b1 || fault_addr !== EXC_VEC)
         begin bad++; $display("FAIL double_fault got=%b/%h/%b/%h", fault, fault_count, halted, fault_addr); end
      drive(0, 0, 0, 0, 32'd0, 1, 32'h0040_0300, 0);
      drive(0, 1, 1, 0, 32'd0, 0, 32'd0, 0);
      total++; if (rom_bus.rom_addr !== EXC_VEC || fault !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b1)
         begin bad++; $display("FAIL halt_frozen got=%h/%b/%b/%b", rom_bus.rom_addr, fault, if_valid, halted); end
      reset = 1'b0;
      #2;
      total++; if (rom_bus.rom_addr !== RESET_VEC || halted !== 1'b0 || fault_count !== 8'd0 || fault_addr !== 32'd0 || if_pc !== 32'd0)
         begin bad++; $display("FAIL halt_reset got=%h/%b/%h/%h/%h", rom_bus.rom_addr, halted, fault_count, fault_addr, if_pc); end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      idle();
      total++; if (if_inst !== 32'h3c11_0040 || if_pc !== RESET_VEC) begin bad++; $display("FAIL after_reset got=%h/%h", if_inst, if_pc); end
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 260; i++) begin
         drive(0, 0, 0, 0, 32'd0, 0, 32'd0, 1);
         total++; if (fault_count !== m_fcount || fault !== 1'b1)
            begin bad++; $display("FAIL sat_count%0d got=%h/%b exp=%h/1", i, fault_count, fault, m_fcount); end
         idle();
      end
      total++; if (fault_count !== 8'hFF || halted !== 1'b0) begin bad++; $display("FAIL sat_final got=%h/%b exp=ff/0", fault_count, halted); end
   endtask

   task automatic test_random();
      logic [31:0] jt, bt;
      int halt_cycles = 0;
      apply_reset();
      for (int i = 0; i < 2000; i++) begin
         jt = {$urandom} & 32'hFFFF_FFFC;
         bt = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) jt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) bt[1:0] = 2'($urandom_range(1, 3));
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7) == 0, jt, $urandom_range(0, 4) == 0, bt, $urandom_range(0, 7) == 0);
         total++; if (rom_bus.rom_addr !== m_pc) begin bad++; $display("FAIL rnd_pc%0d got=%h exp=%h", i, rom_bus.rom_addr, m_pc); end
         total++; if (if_inst !== m_inst || if_pc !== m_ifpc || if_valid !== m_valid || if_pc_plus4 !== m_ifpc + 32'd4)
            begin bad++; $display("FAIL rnd_ifid%0d got=%h/%h/%b exp=%h/%h/%b", i, if_inst, if_pc, if_valid, m_inst, m_ifpc, m_valid); end
         total++; if (fault !== m_fault || fault_addr !== m_faddr || fault_count !== m_fcount || halted !== m_halted)
            begin bad++; $display("FAIL rnd_fault%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", i, fault, fault_addr, fault_count, halted, m_fault, m_faddr, m_fcount, m_halted); end
         if (m_halted) halt_cycles++;
         if (halt_cycles > 4) begin
            halt_cycles = 0;
            apply_reset();
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect();
      test_stall();
      test_fault();
      test_double_fault();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
